// File: rtl/mux1hot_rr_arbiter.sv
// mux1hot_rr_arbiter: round-robin owner of a one-hot mux select, held for a whole packet
// with an optional per-grant beat limit.
module mux1hot_rr_arbiter #(
   parameter int N         = 8,
   parameter int MAX_BEATS = 0,
   parameter int IDX_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     last_i,
   input  logic             out_ready_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             busy_o,
   output logic             out_valid_o,
   output logic [N-1:0]     req_ready_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   if (N < 2 || N > 8 || MAX_BEATS < 0 || MAX_BEATS > 65535 || (1 << IDX_W) < N) begin : g_bad_param
      $error("mux1hot_rr_arbiter: illegal parameter combination");
   end
   state_t           state_q;
   logic [N-1:0]     gnt_q;
   logic [IDX_W-1:0] gnt_idx_q, ptr_q, ptr_d, win_d;
   logic             busy_q, fire, done;
   logic [15:0]      cnt_q;
   always_comb begin
      win_d = ptr_q;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_q) + k) % N]) win_d = IDX_W'((int'(ptr_q) + k) % N);
      end
   end
   assign fire  = (state_q == BUSY) & req_i[gnt_idx_q] & out_ready_i;
   assign done  = fire & (last_i[gnt_idx_q] | ((MAX_BEATS != 0) & (cnt_q == 16'(MAX_BEATS - 1))));
   assign ptr_d = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         busy_q    <= 1'b0;
         ptr_q     <= '0;
         cnt_q     <= '0;
      end else if (state_q == IDLE) begin
         if (|req_i) begin
            state_q   <= BUSY;
            gnt_q     <= N'(1) << win_d;
            gnt_idx_q <= win_d;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
         end
      end else if (fire) begin
         cnt_q <= cnt_q + 1'b1;
         if (done) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
         end
      end
   end
   // gnt_q is zero in IDLE, so both accept paths are quiet without a state term
   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign busy_o      = busy_q;
   assign out_valid_o = busy_q & req_i[gnt_idx_q];
   assign req_ready_o = gnt_q & {N{out_ready_i}};
endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// tb_mux1hot_rr_arbiter: directed and random checks of two arbiter instances
// (unlimited and 2-beat limit) against a packet-level ownership model.
module tb_mux1hot_rr_arbiter;
   localparam int N = 3;
   logic clk = 0, rst = 1, ordy = 0;
   logic [N-1:0] req = '0, lst = '0;
   logic [1:0][N-1:0] gnt, rrdy;
   logic [1:0][2:0] idx;
   logic [1:0] busy, ov;
   int owner[2], ptr[2], cnt[2];
   int maxb[2] = '{0, 2};
   int n_chk = 0, n_fail = 0;
   logic [2:0] seq2[7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
   logic [2:0] seq5[6] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
   logic       pat3[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   mux1hot_rr_arbiter #(.N(N), .MAX_BEATS(0), .IDX_W(3)) u_a (
      .clk(clk), .rst(rst), .req_i(req), .last_i(lst), .out_ready_i(ordy),
      .gnt_o(gnt[0]), .gnt_idx_o(idx[0]), .busy_o(busy[0]), .out_valid_o(ov[0]), .req_ready_o(rrdy[0]));
   mux1hot_rr_arbiter #(.N(N), .MAX_BEATS(2), .IDX_W(3)) u_b (
      .clk(clk), .rst(rst), .req_i(req), .last_i(lst), .out_ready_i(ordy),
      .gnt_o(gnt[1]), .gnt_idx_o(idx[1]), .busy_o(busy[1]), .out_valid_o(ov[1]), .req_ready_o(rrdy[1]));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         owner[m] = -1; ptr[m] = 0; cnt[m] = 0;
      end
   endtask

   // a requester owns the mux from grant until its packet (or its beat allowance) is accepted
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (owner[m] < 0) begin
            for (int k = N - 1; k >= 0; k--)
               if (req[(ptr[m] + k) % N]) owner[m] = (ptr[m] + k) % N;
            cnt[m] = 0;
         end else if (req[owner[m]] && ordy) begin
            cnt[m]++;
            if (lst[owner[m]] || (maxb[m] != 0 && cnt[m] == maxb[m])) begin
               ptr[m] = (owner[m] + 1) % N;
               owner[m] = -1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         logic [N-1:0] eg;
         eg = (owner[m] < 0) ? '0 : N'(1) << owner[m];
         chk($sformatf("gnt%0d", m), 32'(gnt[m]), 32'(eg));
         chk($sformatf("busy%0d", m), 32'(busy[m]), 32'(owner[m] >= 0));
         chk($sformatf("out_valid%0d", m), 32'(ov[m]), 32'(owner[m] >= 0 && req[owner[m]]));
         chk($sformatf("req_ready%0d", m), 32'(rrdy[m]), 32'(ordy ? eg : '0));
         if (owner[m] >= 0) chk($sformatf("gnt_idx%0d", m), 32'(idx[m]), owner[m]);
      end
   endtask

   task automatic tick();
      #1 check_all();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1; model_reset();
      tick();
      rst = 0;
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();
      // idle with no requests
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1_gnt", 32'(gnt[0]), 0);
      end
      // everyone requesting single-beat packets rotates with a bubble between grants
      req = 3'b111; lst = 3'b111; ordy = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("t2_seq%0d", i), 32'(gnt[0]), 32'(seq2[i]));
      end
      // 4-beat packet with a stalling consumer is never preempted
      do_reset();
      req = 3'b010; lst = '0; ordy = 0;
      tick();
      chk("t3_grant", 32'(gnt[0]), 32'(3'b010));
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         ordy = pat3[i]; lst = (i >= 4) ? 3'b010 : 3'b000;
         tick();
         chk($sformatf("t3_hold%0d", i), 32'(gnt[0]), (i == 5) ? 32'(0) : 32'(3'b010));
      end
      // owner drops its request mid-packet while another requester waits
      do_reset();
      req = 3'b001; lst = '0; ordy = 1;
      tick();
      req = 3'b101;
      tick();
      req = 3'b100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_gnt", 32'(gnt[0]), 32'(3'b001));
         chk("t4_ov", 32'(ov[0]), 0);
      end
      req = 3'b101; lst = 3'b001;
      tick();
      chk("t4_release", 32'(gnt[0]), 0);
      // beat limit forces release and the pointer wraps back to 0
      do_reset();
      req = 3'b011; lst = 3'b010; ordy = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t5_seq%0d", i), 32'(gnt[1]), 32'(seq5[i]));
      end
      // async reset drops a live grant before the next edge
      do_reset();
      req = 3'b100; lst = '0;
      tick();
      chk("t6_grant", 32'(gnt[0]), 32'(3'b100));
      #2 rst = 1; model_reset();
      #1 chk("t6_async_a", 32'(gnt[0]), 0);
      chk("t6_async_b", 32'(gnt[1]), 0);
      tick();
      rst = 0; req = 3'b111; lst = 3'b111;
      tick();
      chk("t6_restart", 32'(gnt[0]), 32'(3'b001));
      // random traffic
      do_reset();
      for (int i = 0; i < 500; i++) begin
         req = N'($urandom); lst = N'($urandom); ordy = ($urandom_range(0, 3) != 0);
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
